run_limit_serializer: RTL and testbench

- Parallel-to-serial stage directly upstream of the consecutive-bit run detector; drives that detector's serial input x.
- Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per clock.
- Bit-stuffing: after MAX_RUN identical consecutive bits, inserts one complement bit, so a compliant stream never exceeds MAX_RUN identical bits.
- The downstream detector therefore flags only stuffed-line violations or corruption.

---
 rtl/run_limit_serializer_pkg.sv | 22 ++
 rtl/run_limit_serializer.sv | 142 ++++++++++++++
 tb/tb_run_limit_serializer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/run_limit_serializer_pkg.sv
// rtl/run_limit_serializer_pkg.sv - shared constants, state encoding and helpers for the run-limited serial line
//
// Holds the line-wide defaults so the serializer and the downstream run
// detector agree on one MAX_RUN, the serializer FSM state encoding, and the
// width helper for the run-length counter.
package run_limit_serializer_pkg;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_MAX_RUN = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;  // nothing on x
    localparam state_t ST_DATA  = 2'd1;  // data bit on x
    localparam state_t ST_STUFF = 2'd2;  // stuff bit on x

    // Run counter must hold 0..max_run inclusive.
    function automatic int run_len_width(input int max_run);
        return $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/run_limit_serializer.sv
// rtl/run_limit_serializer.sv - bit-stuffing parallel-to-serial stage feeding the run detector
//
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock. After MAX_RUN identical consecutive bits on the line a
// complement stuff bit is inserted, so the line never carries a longer run.
//
// Ports:
//   clk       clock
//   reset     asynchronous, active-high reset
//   in_data   parallel word, sampled only at accept
//   in_valid  in_data valid
//   in_ready  word can be accepted this cycle (from registered state only)
//   x         serial bit (registered)
//   x_valid   x carries a bit this cycle
//   x_stuff   x is an inserted stuff bit
//   x_first   x is the first data bit of a word
module run_limit_serializer
    import run_limit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_RUN   = DEFAULT_MAX_RUN,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             x_stuff,
    output logic             x_first
);

    localparam int RLW = run_len_width(MAX_RUN);
    localparam int CW  = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;     // remaining data bits, next one at the head
    logic [CW-1:0]    rem;       // data bits still to send after the current one
    logic             run_bit;
    logic [RLW-1:0]   run_len;

    state_t           nxt_state;
    logic [WIDTH-1:0] nxt_shreg;
    logic [CW-1:0]    nxt_rem;
    logic             nxt_bit;
    logic             nxt_valid;
    logic             nxt_stuff;
    logic             nxt_first;
    logic             nxt_run_bit;
    logic [RLW-1:0]   nxt_run_len;

    logic             stuff_due;
    logic             final_slot;
    logic             accept;
    logic             head_in;
    logic             head_sh;
    logic [WIDTH-1:0] shifted_in;
    logic [WIDTH-1:0] shifted_sh;

    // The bit now on x completed a maximal run: the next slot must be a stuff bit.
    assign stuff_due  = (state == ST_DATA) && (run_len == RLW'(MAX_RUN));

    // Last data bit with no stuff owed, or the stuff bit right after the last data bit.
    assign final_slot = (rem == '0) &&
                        (((state == ST_DATA) && !stuff_due) || (state == ST_STUFF));

    assign in_ready   = (state == ST_IDLE) || final_slot;
    assign accept     = in_valid && in_ready;

    assign head_in    = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign head_sh    = MSB_FIRST ? shreg[WIDTH-1]   : shreg[0];
    assign shifted_in = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
    assign shifted_sh = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}   : {1'b0, shreg[WIDTH-1:1]};

    always_comb begin
        nxt_state = ST_IDLE;
        nxt_shreg = shreg;
        nxt_rem   = rem;
        nxt_bit   = 1'b0;
        nxt_valid = 1'b0;
        nxt_stuff = 1'b0;
        nxt_first = 1'b0;

        if (stuff_due) begin
            nxt_state = ST_STUFF;
            nxt_bit   = ~run_bit;
            nxt_valid = 1'b1;
            nxt_stuff = 1'b1;
        end else if ((state != ST_IDLE) && (rem != '0)) begin
            nxt_state = ST_DATA;
            nxt_bit   = head_sh;
            nxt_valid = 1'b1;
            nxt_shreg = shifted_sh;
            nxt_rem   = rem - CW'(1);
        end else if (accept) begin
            // First bit goes straight from in_data; the shift register keeps the rest.
            nxt_state = ST_DATA;
            nxt_bit   = head_in;
            nxt_valid = 1'b1;
            nxt_first = 1'b1;
            nxt_shreg = shifted_in;
            nxt_rem   = CW'(WIDTH - 1);
        end

        // Runs follow the line, stuff bits included; an idle slot breaks the run.
        nxt_run_bit = nxt_valid ? nxt_bit : run_bit;
        if (!nxt_valid) begin
            nxt_run_len = '0;
        end else if ((run_len != '0) && (nxt_bit == run_bit)) begin
            nxt_run_len = run_len + RLW'(1);
        end else begin
            nxt_run_len = RLW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            rem     <= '0;
            run_bit <= 1'b0;
            run_len <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            x_stuff <= 1'b0;
            x_first <= 1'b0;
        end else begin
            state   <= nxt_state;
            shreg   <= nxt_shreg;
            rem     <= nxt_rem;
            run_bit <= nxt_run_bit;
            run_len <= nxt_run_len;
            x       <= nxt_bit;
            x_valid <= nxt_valid;
            x_stuff <= nxt_stuff;
            x_first <= nxt_first;
        end
    end

endmodule

// File: tb/tb_run_limit_serializer.sv
// tb/tb_run_limit_serializer.sv - directed self-checking bench for run_limit_serializer
module tb_run_limit_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid1 = 1'b0;
    logic       in_valid2 = 1'b0;

    logic in_ready1, x1, x1_valid, x1_stuff, x1_first;
    logic in_ready2, x2, x2_valid, x2_stuff, x2_first;

    int tests = 0;
    int fails = 0;

    // Selects which instance the capture task drives and observes.
    logic sel = 1'b0;
    logic o_ready, o_x, o_valid, o_stuff, o_first;

    // Slot i of an n-slot capture lands at bit n-1-i, so literals read in time order.
    logic [31:0] cap_x, cap_valid, cap_stuff, cap_first, cap_ready, cap_acc;

    int  len1 = 0, max1 = 0, len2 = 0, max2 = 0;
    logic rb1 = 1'b0, rb2 = 1'b0;

    run_limit_serializer #(.WIDTH(8), .MAX_RUN(3), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid1),
        .in_ready(in_ready1), .x(x1), .x_valid(x1_valid), .x_stuff(x1_stuff), .x_first(x1_first)
    );

    run_limit_serializer #(.WIDTH(8), .MAX_RUN(3), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid2),
        .in_ready(in_ready2), .x(x2), .x_valid(x2_valid), .x_stuff(x2_stuff), .x_first(x2_first)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_ready = sel ? in_ready2 : in_ready1;
        o_x     = sel ? x2        : x1;
        o_valid = sel ? x2_valid  : x1_valid;
        o_stuff = sel ? x2_stuff  : x1_stuff;
        o_first = sel ? x2_first  : x1_first;
    end

    // Stand-in for the downstream run detector: longest run seen on each line.
    always @(negedge clk) begin
        if (reset) begin
            len1 = 0;
            len2 = 0;
        end else begin
            if (x1_valid) begin
                if (len1 != 0 && x1 == rb1) len1++; else len1 = 1;
                rb1 = x1;
                if (len1 > max1) max1 = len1;
            end else len1 = 0;
            if (x2_valid) begin
                if (len2 != 0 && x2 == rb2) len2++; else len2 = 1;
                rb2 = x2;
                if (len2 > max2) max2 = len2;
            end else len2 = 0;
        end
    end

    task automatic drive_valid(input logic v);
        if (sel) in_valid2 = v; else in_valid1 = v;
    endtask

    // Offers word a (then b if two), waits for accept, captures n slots.
    task automatic run_slots(input logic [7:0] a, input logic [7:0] b, input bit two, input int n);
        int guard;
        bit acc;
        cap_x = '0; cap_valid = '0; cap_stuff = '0; cap_first = '0; cap_ready = '0; cap_acc = '0;
        in_data = a;
        drive_valid(1'b1);
        guard = 0;
        while (o_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_wait: in_ready=%b required 1", o_ready);
        end
        @(posedge clk); #1;
        if (two) in_data = b;
        else begin
            drive_valid(1'b0);
            in_data = ~a;
        end
        for (int i = 0; i < n; i++) begin
            cap_x[n-1-i]     = o_x;
            cap_valid[n-1-i] = o_valid;
            cap_stuff[n-1-i] = o_stuff;
            cap_first[n-1-i] = o_first;
            cap_ready[n-1-i] = o_ready;
            if (i < n - 1) begin
                acc = ((sel ? in_valid2 : in_valid1) === 1'b1) && (o_ready === 1'b1);
                @(posedge clk); #1;
                if (acc) begin
                    cap_acc[n-1-i] = 1'b1;
                    drive_valid(1'b0);
                    in_data = ~b;
                end
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if ({x1, x1_valid, x1_stuff, x1_first} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0000", {x1, x1_valid, x1_stuff, x1_first});
        end
        tests++;
        if ({in_ready1, in_ready2} !== 2'b11) begin
            fails++;
            $display("FAIL reset_ready: got %b required 11", {in_ready1, in_ready2});
        end
        #10 reset = 1'b0;
        #1;
        tests++;
        if ({x1, x1_valid, x1_stuff, x1_first, x2_valid, in_ready1} !== 6'b000001) begin
            fails++;
            $display("FAIL post_reset_state: got %b required 000001",
                     {x1, x1_valid, x1_stuff, x1_first, x2_valid, in_ready1});
        end
    endtask

    task automatic test_reset_mid_word();
        sel = 1'b0;
        run_slots(8'hFF, 8'h00, 1'b0, 4);
        tests++;
        if (cap_x !== 32'b1110 || cap_stuff !== 32'b0001) begin
            fails++;
            $display("FAIL pre_reset_stream: x=%b stuff=%b required x=1110 stuff=0001", cap_x[3:0], cap_stuff[3:0]);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({x1, x1_valid, x1_stuff, x1_first, in_ready1} !== 5'b00001) begin
            fails++;
            $display("FAIL async_reset_mid_word: got %b required 00001",
                     {x1, x1_valid, x1_stuff, x1_first, in_ready1});
        end
        #3 reset = 1'b0;
        // 00 after a broken 1-run: a leftover run or shift state would shift the stuff positions.
        run_slots(8'h00, 8'h00, 1'b0, 10);
        tests++;
        if (cap_x !== 32'b0001000100 || cap_stuff !== 32'b0001000100 || cap_first !== 32'b1000000000) begin
            fails++;
            $display("FAIL no_residue: x=%b stuff=%b first=%b required 0001000100 0001000100 1000000000",
                     cap_x[9:0], cap_stuff[9:0], cap_first[9:0]);
        end
        settle();
    endtask

    task automatic test_plain_word();
        sel = 1'b0;
        run_slots(8'hA5, 8'h00, 1'b0, 8);
        tests++;
        if (cap_x !== 32'hA5 || cap_valid !== 32'hFF) begin
            fails++;
            $display("FAIL a5_bits: x=%b valid=%b required 10100101 11111111", cap_x[7:0], cap_valid[7:0]);
        end
        tests++;
        if (cap_stuff !== 32'h00 || cap_first !== 32'b10000000) begin
            fails++;
            $display("FAIL a5_flags: stuff=%b first=%b required 00000000 10000000", cap_stuff[7:0], cap_first[7:0]);
        end
        tests++;
        if (cap_ready !== 32'b00000001) begin
            fails++;
            $display("FAIL a5_ready: got %b required 00000001", cap_ready[7:0]);
        end
        @(posedge clk); #1;
        tests++;
        if ({o_valid, o_x, o_stuff, o_first, o_ready} !== 5'b00001) begin
            fails++;
            $display("FAIL idle_after_word: got %b required 00001", {o_valid, o_x, o_stuff, o_first, o_ready});
        end
        settle();
    endtask

    task automatic test_stuffing();
        sel = 1'b0;
        run_slots(8'hE0, 8'h00, 1'b0, 11);
        tests++;
        if (cap_x !== 32'b11100010001 || cap_stuff !== 32'b00010010001) begin
            fails++;
            $display("FAIL e0_stream: x=%b stuff=%b required 11100010001 00010010001", cap_x[10:0], cap_stuff[10:0]);
        end
        tests++;
        if (cap_ready !== 32'b00000000001 || cap_valid !== 32'h7FF) begin
            fails++;
            $display("FAIL e0_ready: ready=%b valid=%b required 00000000001 11111111111", cap_ready[10:0], cap_valid[10:0]);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        run_slots(8'hFF, 8'h00, 1'b1, 20);
        tests++;
        if (cap_x !== 32'b1110_1110_1100_0100_0100 || cap_stuff !== 32'b0001_0001_0000_0100_0100) begin
            fails++;
            $display("FAIL b2b_stream: x=%b stuff=%b required 11101110110001000100 00010001000001000100",
                     cap_x[19:0], cap_stuff[19:0]);
        end
        tests++;
        if (cap_valid !== 32'hFFFFF || cap_first !== 32'b1000_0000_0010_0000_0000) begin
            fails++;
            $display("FAIL b2b_valid_first: valid=%b first=%b required all ones 10000000001000000000",
                     cap_valid[19:0], cap_first[19:0]);
        end
        tests++;
        if (cap_acc !== 32'b0000_0000_0100_0000_0000 || cap_ready !== 32'b0000_0000_0100_0000_0001) begin
            fails++;
            $display("FAIL b2b_accept_slot: acc=%b ready=%b required 00000000010000000000 00000000010000000001",
                     cap_acc[19:0], cap_ready[19:0]);
        end
        settle();
    endtask

    task automatic test_gap_breaks_run();
        sel = 1'b0;
        run_slots(8'h13, 8'h00, 1'b0, 9);
        tests++;
        if (cap_x !== 32'b000110011 || cap_stuff !== 32'b000100000) begin
            fails++;
            $display("FAIL gap_first_word: x=%b stuff=%b required 000110011 000100000", cap_x[8:0], cap_stuff[8:0]);
        end
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL gap_idle1: x_valid=%b required 0", o_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL gap_idle2: x_valid=%b required 0", o_valid);
        end
        run_slots(8'hC0, 8'h00, 1'b0, 10);
        tests++;
        if (cap_x !== 32'b1100010001 || cap_stuff !== 32'b0000010001) begin
            fails++;
            $display("FAIL gap_second_word: x=%b stuff=%b required 1100010001 0000010001", cap_x[9:0], cap_stuff[9:0]);
        end
        settle();
    endtask

    task automatic test_lsb_first();
        sel = 1'b1;
        run_slots(8'h0F, 8'h00, 1'b0, 10);
        tests++;
        if (cap_x !== 32'b1110100010 || cap_stuff !== 32'b0001000010) begin
            fails++;
            $display("FAIL lsb_stream: x=%b stuff=%b required 1110100010 0001000010", cap_x[9:0], cap_stuff[9:0]);
        end
        tests++;
        if (cap_first !== 32'b1000000000 || cap_ready !== 32'b0000000001) begin
            fails++;
            $display("FAIL lsb_flags: first=%b ready=%b required 1000000000 0000000001", cap_first[9:0], cap_ready[9:0]);
        end
        settle();
        sel = 1'b0;
    endtask

    task automatic test_run_limit();
        tests++;
        if (max1 != 3) begin
            fails++;
            $display("FAIL run_limit_msb: longest run %0d required 3", max1);
        end
        tests++;
        if (max2 != 3) begin
            fails++;
            $display("FAIL run_limit_lsb: longest run %0d required 3", max2);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_word();
        test_plain_word();
        test_stuffing();
        test_back_to_back();
        test_gap_breaks_run();
        test_lsb_first();
        test_run_limit();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
